// File: rtl/measure.sv
// measure: two-port 10GbE latency-measurement engine (XGMII, 156.25 MHz).
//
// Port 0 TX sends a fixed 64-byte timestamped probe every GAP cycles.
// Port 1 RX receives probes and reports one-way latency in cycles, plus
// good/bad frame counts. Port 1 TX is held idle and port 0 RX is ignored.
//
// Parameters:
//   GAP  start-to-start probe period in cycles (values below 16 act as 16)
//   SA   source MAC address carried in every probe
//
// Ports:
//   sys_clk                    clock, all logic on the rising edge
//   sys_rst                    asynchronous active-low reset
//   xgmii_0_txd/txc            probe transmitter (lane 0 first on the wire)
//   xgmii_0_rxd/rxc            unused
//   xgmii_1_txd/txc            constant idle
//   xgmii_1_rxd/rxc            probe receiver
//   latency                    latency of the last good probe, in cycles
//   latency_valid              one-cycle pulse when latency updates
//   tx_count, rx_good, rx_bad  wrapping 32-bit statistics
//
// Optional build macro:
//   MEASURE_FCS_EN  probes carry an IEEE 802.3 CRC-32 in bytes 60-63 and the
//                   receiver rejects frames whose CRC does not match. When
//                   undefined, bytes 60-63 are zero and are not checked.
`timescale 1ns/1ps

module measure #(
  parameter int unsigned GAP = 64,
  parameter logic [47:0] SA  = 48'h001122334455
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [63:0] xgmii_0_txd,
  output logic [7:0]  xgmii_0_txc,
  input  logic [63:0] xgmii_0_rxd,
  input  logic [7:0]  xgmii_0_rxc,
  output logic [63:0] xgmii_1_txd,
  output logic [7:0]  xgmii_1_txc,
  input  logic [63:0] xgmii_1_rxd,
  input  logic [7:0]  xgmii_1_rxc,
  output logic [31:0] latency,
  output logic        latency_valid,
  output logic [31:0] tx_count,
  output logic [31:0] rx_good,
  output logic [31:0] rx_bad
);

  localparam int unsigned PERIOD   = (GAP < 16) ? 16 : GAP;
  localparam logic [31:0] LAST_TICK = 32'(PERIOD - 1);
  localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C   = 8'hFF;
  localparam logic [63:0] START_D  = 64'hD5555555555555FB;
  localparam logic [7:0]  START_C  = 8'h01;
  localparam logic [63:0] TERM_D   = 64'h07070707070707FD;

  typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_TERM} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_TERM} rx_state_t;

  // Probe byte k (0..63) excluding the FCS, which is patched in separately.
  function automatic logic [7:0] frame_byte(input logic [5:0] k,
                                            input logic [31:0] seq,
                                            input logic [31:0] ts);
    logic [7:0] b;
    b = 8'h00;
    case (k)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: b = 8'hFF;
      6'd6:  b = SA[47:40];
      6'd7:  b = SA[39:32];
      6'd8:  b = SA[31:24];
      6'd9:  b = SA[23:16];
      6'd10: b = SA[15:8];
      6'd11: b = SA[7:0];
      6'd12: b = 8'h88;
      6'd13: b = 8'hB5;
      6'd14: b = 8'h4D;
      6'd15: b = 8'h45;
      6'd16: b = 8'h41;
      6'd17: b = 8'h53;
      6'd18: b = seq[31:24];
      6'd19: b = seq[23:16];
      6'd20: b = seq[15:8];
      6'd21: b = seq[7:0];
      6'd22: b = ts[31:24];
      6'd23: b = ts[23:16];
      6'd24: b = ts[15:8];
      6'd25: b = ts[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Data word idx (0..7) holds frame bytes 8*idx .. 8*idx+7, lane 0 first.
  function automatic logic [63:0] frame_word(input logic [2:0] idx,
                                             input logic [31:0] seq,
                                             input logic [31:0] ts);
    logic [63:0] w;
    w = 64'h0;
    for (int l = 0; l < 8; l++)
      w[8*l +: 8] = frame_byte({idx, 3'(l)}, seq, ts);
    return w;
  endfunction

`ifdef MEASURE_FCS_EN
  // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [7:0] b);
    logic [31:0] c;
    c = crc_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction
`endif

  logic [31:0] cyc;
  logic [31:0] tx_timer;
  tx_state_t   tx_state;
  logic [2:0]  tx_idx;
  logic [31:0] tx_seq;
  logic [31:0] tx_ts;
  logic [63:0] tx_base;
  logic [63:0] tx_word;

  rx_state_t   rx_state;
  logic [2:0]  rx_idx;
  logic [31:0] rx_arr;
  logic [31:0] rx_ts;
  logic        rx_ok;
  logic        rx_start;
  logic        rx_term;
  logic        rx_err;
  logic        rx_word_ok;

`ifdef MEASURE_FCS_EN
  logic [31:0] tx_crc;
  logic [31:0] tx_crc_next;
  logic [31:0] tx_crc_tail;
  logic [31:0] rx_crc;
  logic [31:0] rx_crc_next;
  logic [31:0] rx_crc_tail;
`endif

  // Port 0 receive pins are intentionally ignored.
  logic unused_rx0;
  assign unused_rx0 = ^{xgmii_0_rxd, xgmii_0_rxc};

  assign xgmii_1_txd = IDLE_D;
  assign xgmii_1_txc = IDLE_C;

  // Free-running cycle counter; its value while a start word is on the wire
  // is both the TX timestamp and the RX arrival time.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) cyc <= 32'd0;
    else          cyc <= cyc + 32'd1;
  end

  // Next probe data word. The final data word gets the FCS in lanes 4-7,
  // computed from the running CRC plus the first four bytes of that word.
  always_comb begin
    tx_base = frame_word(tx_idx, tx_seq, tx_ts);
    tx_word = tx_base;
`ifdef MEASURE_FCS_EN
    tx_crc_next = tx_crc;
    for (int l = 0; l < 8; l++)
      tx_crc_next = crc_byte(tx_crc_next, tx_base[8*l +: 8]);
    tx_crc_tail = tx_crc;
    for (int l = 0; l < 4; l++)
      tx_crc_tail = crc_byte(tx_crc_tail, tx_base[8*l +: 8]);
    if (tx_idx == 3'd7) tx_word[63:32] = ~tx_crc_tail;
`endif
  end

  // Probe transmitter. The period timer runs independently of the frame
  // sequencer so probes start exactly every PERIOD cycles; the start word is
  // loaded on the edge that ends the PERIOD-th cycle, so it carries cyc+1.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      tx_timer    <= 32'd0;
      tx_state    <= TX_IDLE;
      tx_idx      <= 3'd0;
      tx_seq      <= 32'd0;
      tx_ts       <= 32'd0;
      tx_count    <= 32'd0;
      xgmii_0_txd <= IDLE_D;
      xgmii_0_txc <= IDLE_C;
`ifdef MEASURE_FCS_EN
      tx_crc      <= 32'hFFFFFFFF;
`endif
    end else begin
      if (tx_timer == LAST_TICK) tx_timer <= 32'd0;
      else                       tx_timer <= tx_timer + 32'd1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_timer == LAST_TICK) begin
            xgmii_0_txd <= START_D;
            xgmii_0_txc <= START_C;
            tx_ts       <= cyc + 32'd1;
            tx_idx      <= 3'd0;
            tx_state    <= TX_DATA;
`ifdef MEASURE_FCS_EN
            tx_crc      <= 32'hFFFFFFFF;
`endif
          end else begin
            xgmii_0_txd <= IDLE_D;
            xgmii_0_txc <= IDLE_C;
          end
        end
        TX_DATA: begin
          xgmii_0_txd <= tx_word;
          xgmii_0_txc <= 8'h00;
          tx_idx      <= tx_idx + 3'd1;
`ifdef MEASURE_FCS_EN
          tx_crc      <= tx_crc_next;
`endif
          if (tx_idx == 3'd7) tx_state <= TX_TERM;
        end
        TX_TERM: begin
          xgmii_0_txd <= TERM_D;
          xgmii_0_txc <= 8'hFF;
          tx_count    <= tx_count + 32'd1;
          tx_seq      <= tx_seq + 32'd1;
          tx_state    <= TX_IDLE;
        end
        default: begin
          xgmii_0_txd <= IDLE_D;
          xgmii_0_txc <= IDLE_C;
          tx_state    <= TX_IDLE;
        end
      endcase
    end
  end

  // Receive-word classification. Header checks cover bytes 12-17, which sit
  // in lanes 4-7 of data word 1 and lanes 0-1 of data word 2.
  always_comb begin
    rx_start = (xgmii_1_rxc == 8'h01) && (xgmii_1_rxd[7:0] == 8'hFB);
    rx_term  = xgmii_1_rxc[0] && (xgmii_1_rxd[7:0] == 8'hFD);
    rx_err   = 1'b0;
    for (int l = 0; l < 8; l++)
      if (xgmii_1_rxc[l] && (xgmii_1_rxd[8*l +: 8] == 8'hFE)) rx_err = 1'b1;
    rx_word_ok = 1'b1;
    case (rx_idx)
      3'd1:    rx_word_ok = (xgmii_1_rxd[63:32] == 32'h454DB588);
      3'd2:    rx_word_ok = (xgmii_1_rxd[15:0] == 16'h5341);
      default: rx_word_ok = 1'b1;
    endcase
`ifdef MEASURE_FCS_EN
    rx_crc_next = rx_crc;
    for (int l = 0; l < 8; l++)
      rx_crc_next = crc_byte(rx_crc_next, xgmii_1_rxd[8*l +: 8]);
    rx_crc_tail = rx_crc;
    for (int l = 0; l < 4; l++)
      rx_crc_tail = crc_byte(rx_crc_tail, xgmii_1_rxd[8*l +: 8]);
    if ((rx_idx == 3'd7) && (xgmii_1_rxd[63:32] != ~rx_crc_tail))
      rx_word_ok = 1'b0;
`endif
  end

  // Probe receiver. Any start that interrupts a frame counts the interrupted
  // frame as bad and immediately begins a new one.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_state      <= RX_IDLE;
      rx_idx        <= 3'd0;
      rx_arr        <= 32'd0;
      rx_ts         <= 32'd0;
      rx_ok         <= 1'b0;
      latency       <= 32'd0;
      latency_valid <= 1'b0;
      rx_good       <= 32'd0;
      rx_bad        <= 32'd0;
`ifdef MEASURE_FCS_EN
      rx_crc        <= 32'hFFFFFFFF;
`endif
    end else begin
      latency_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_start) begin
            rx_arr   <= cyc;
            rx_idx   <= 3'd0;
            rx_ok    <= 1'b1;
            rx_state <= RX_DATA;
`ifdef MEASURE_FCS_EN
            rx_crc   <= 32'hFFFFFFFF;
`endif
          end
        end
        RX_DATA: begin
          if (xgmii_1_rxc != 8'h00) begin
            rx_bad <= rx_bad + 32'd1;
            if (rx_start) begin
              rx_arr <= cyc;
              rx_idx <= 3'd0;
              rx_ok  <= 1'b1;
`ifdef MEASURE_FCS_EN
              rx_crc <= 32'hFFFFFFFF;
`endif
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_ok  <= rx_ok & rx_word_ok;
            rx_idx <= rx_idx + 3'd1;
`ifdef MEASURE_FCS_EN
            rx_crc <= rx_crc_next;
`endif
            if (rx_idx == 3'd2) rx_ts[31:16] <= {xgmii_1_rxd[55:48], xgmii_1_rxd[63:56]};
            if (rx_idx == 3'd3) rx_ts[15:0]  <= {xgmii_1_rxd[7:0], xgmii_1_rxd[15:8]};
            if (rx_idx == 3'd7) rx_state <= RX_TERM;
          end
        end
        RX_TERM: begin
          if (rx_term && !rx_err && rx_ok) begin
            latency       <= rx_arr - rx_ts;
            latency_valid <= 1'b1;
            rx_good       <= rx_good + 32'd1;
            rx_state      <= RX_IDLE;
          end else begin
            rx_bad <= rx_bad + 32'd1;
            if (rx_start) begin
              rx_arr   <= cyc;
              rx_idx   <= 3'd0;
              rx_ok    <= 1'b1;
              rx_state <= RX_DATA;
`ifdef MEASURE_FCS_EN
              rx_crc   <= 32'hFFFFFFFF;
`endif
            end else begin
              rx_state <= RX_IDLE;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_measure.sv
`timescale 1ns/1ps

module tb_measure;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_D  = 64'h07070707070707FD;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [63:0] xgmii_0_txd;
  logic [7:0]  xgmii_0_txc;
  logic [63:0] xgmii_0_rxd;
  logic [7:0]  xgmii_0_rxc;
  logic [63:0] xgmii_1_txd;
  logic [7:0]  xgmii_1_txc;
  logic [63:0] xgmii_1_rxd;
  logic [7:0]  xgmii_1_rxc;
  logic [31:0] latency;
  logic        latency_valid;
  logic [31:0] tx_count;
  logic [31:0] rx_good;
  logic [31:0] rx_bad;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Receive path selection: 0 direct wire, 1 five-stage delay, 2 manual drive.
  int          mode = 2;
  logic        corrupt_hdr = 1'b0;
  logic        flip_payload = 1'b0;
  logic [63:0] man_d = IDLE_D;
  logic [7:0]  man_c = 8'hFF;
  logic        seen_valid = 1'b0;
  logic [63:0] pipe_d [5];
  logic [7:0]  pipe_c [5];
  int          tx_widx;
  int          cur_idx;
  logic [63:0] cap_d;
  logic [31:0] tb_cyc;

  assign xgmii_0_rxd = 64'h0;
  assign xgmii_0_rxc = 8'h00;

  measure #(.GAP(64), .SA(48'h001122334455)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .xgmii_0_txd   (xgmii_0_txd),
    .xgmii_0_txc   (xgmii_0_txc),
    .xgmii_0_rxd   (xgmii_0_rxd),
    .xgmii_0_rxc   (xgmii_0_rxc),
    .xgmii_1_txd   (xgmii_1_txd),
    .xgmii_1_txc   (xgmii_1_txc),
    .xgmii_1_rxd   (xgmii_1_rxd),
    .xgmii_1_rxc   (xgmii_1_rxc),
    .latency       (latency),
    .latency_valid (latency_valid),
    .tx_count      (tx_count),
    .rx_good       (rx_good),
    .rx_bad        (rx_bad)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference cycle count: equals the DUT's CYC in the current cycle.
  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) tb_cyc <= 32'd0;
    else          tb_cyc <= tb_cyc + 32'd1;
  end

  // Word position within the transmitted probe (0 = start word) and
  // optional fault injection on the delayed loopback path.
  always_comb begin
    if ((xgmii_0_txc == 8'h01) && (xgmii_0_txd[7:0] == 8'hFB)) cur_idx = 0;
    else if (tx_widx < 15) cur_idx = tx_widx + 1;
    else cur_idx = 15;
    cap_d = xgmii_0_txd;
    if (corrupt_hdr && (cur_idx == 2)) cap_d[55:48] = 8'h00;
    if (flip_payload && (cur_idx == 4)) cap_d[48] = ~cap_d[48];
  end

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < 5; i++) begin
        pipe_d[i] <= IDLE_D;
        pipe_c[i] <= 8'hFF;
      end
      tx_widx <= 15;
    end else begin
      pipe_d[0] <= cap_d;
      pipe_c[0] <= xgmii_0_txc;
      for (int i = 1; i < 5; i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_c[i] <= pipe_c[i-1];
      end
      tx_widx <= cur_idx;
    end
  end

  always_comb begin
    case (mode)
      0:       begin xgmii_1_rxd = xgmii_0_txd; xgmii_1_rxc = xgmii_0_txc; end
      1:       begin xgmii_1_rxd = pipe_d[4];   xgmii_1_rxc = pipe_c[4];   end
      default: begin xgmii_1_rxd = man_d;       xgmii_1_rxc = man_c;       end
    endcase
  end

  // Expected probe byte k (0..59) from the frame layout.
  function automatic logic [7:0] exp_byte(input int k, input logic [31:0] seq,
                                          input logic [31:0] ts);
    logic [47:0] sa;
    logic [47:0] hdr;
    sa  = 48'h001122334455;
    hdr = 48'h88B54D454153;
    if (k < 6)       return 8'hFF;
    else if (k < 12) return sa[8*(11-k) +: 8];
    else if (k < 18) return hdr[8*(17-k) +: 8];
    else if (k < 22) return seq[8*(21-k) +: 8];
    else if (k < 26) return ts[8*(25-k) +: 8];
    else             return 8'h00;
  endfunction

  function automatic logic [31:0] exp_fcs(input logic [31:0] seq, input logic [31:0] ts);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 60; k++) begin
      c = c ^ {24'h0, exp_byte(k, seq, ts)};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [63:0] exp_word(input int w, input logic [31:0] seq,
                                           input logic [31:0] ts);
    logic [63:0] d;
    logic [31:0] f;
    f = 32'h0;
`ifdef MEASURE_FCS_EN
    if (w == 7) f = exp_fcs(seq, ts);
`endif
    for (int l = 0; l < 8; l++) begin
      if (8*w + l < 60) d[8*l +: 8] = exp_byte(8*w + l, seq, ts);
      else              d[8*l +: 8] = f[8*(8*w + l - 60) +: 8];
    end
    return d;
  endfunction

  task automatic do_reset(input int m);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    mode = m;
    man_d = IDLE_D;
    man_c = 8'hFF;
    corrupt_hdr = 1'b0;
    flip_payload = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    man_d = d;
    man_c = c;
    @(negedge sys_clk);
    if (latency_valid) seen_valid = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; (i < budget) && !got; i++) begin
      @(negedge sys_clk);
      if (latency_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    mode = 2;
    repeat (2) @(negedge sys_clk);
    total_cnt++; if ({xgmii_0_txd, xgmii_0_txc} !== {IDLE_D, 8'hFF}) $display("[TB] FAIL rst_tx0 got %h/%h expected %h/ff", xgmii_0_txd, xgmii_0_txc, IDLE_D); else pass_cnt++;
    total_cnt++; if ({tx_count, rx_good, rx_bad, latency, latency_valid} !== 129'h0) $display("[TB] FAIL rst_stats got %h %h %h %h %b expected zeros", tx_count, rx_good, rx_bad, latency, latency_valid); else pass_cnt++;
    sys_rst = 1'b1;
    repeat (63) @(negedge sys_clk);
    total_cnt++; if (xgmii_0_txc !== 8'hFF) $display("[TB] FAIL early_start txc got %h expected ff", xgmii_0_txc); else pass_cnt++;
    @(negedge sys_clk);
    total_cnt++; if ({xgmii_0_txd, xgmii_0_txc} !== {START_D, 8'h01}) $display("[TB] FAIL start_word got %h/%h expected %h/01", xgmii_0_txd, xgmii_0_txc, START_D); else pass_cnt++;
    for (int w = 0; w < 8; w++) begin
      @(negedge sys_clk);
      total_cnt++; if ({xgmii_0_txd, xgmii_0_txc} !== {exp_word(w, 32'd0, 32'd64), 8'h00}) $display("[TB] FAIL data_word%0d got %h/%h expected %h/00", w, xgmii_0_txd, xgmii_0_txc, exp_word(w, 32'd0, 32'd64)); else pass_cnt++;
    end
    @(negedge sys_clk);
    total_cnt++; if ({xgmii_0_txd, xgmii_0_txc} !== {TERM_D, 8'hFF}) $display("[TB] FAIL term_word got %h/%h expected %h/ff", xgmii_0_txd, xgmii_0_txc, TERM_D); else pass_cnt++;
    total_cnt++; if (tx_count !== 32'd1) $display("[TB] FAIL tx_count_first got %0d expected 1", tx_count); else pass_cnt++;
    total_cnt++; if ({xgmii_1_txd, xgmii_1_txc} !== {IDLE_D, 8'hFF}) $display("[TB] FAIL tx1_idle got %h/%h expected %h/ff", xgmii_1_txd, xgmii_1_txc, IDLE_D); else pass_cnt++;
    total_cnt++; if ({rx_good, rx_bad} !== 64'h0) $display("[TB] FAIL no_rx_counts got %0d/%0d expected 0/0", rx_good, rx_bad); else pass_cnt++;
  endtask

  task automatic test_loop_delay5;
    bit got;
    do_reset(1);
    for (int p = 0; p < 3; p++) begin
      wait_valid(300, got);
      total_cnt++; if (got !== 1'b1) $display("[TB] FAIL d5_valid%0d got %b expected 1", p, got); else pass_cnt++;
      total_cnt++; if (latency !== 32'd5) $display("[TB] FAIL d5_latency%0d got %0d expected 5", p, latency); else pass_cnt++;
    end
    total_cnt++; if (tx_count !== 32'd3) $display("[TB] FAIL d5_tx_count got %0d expected 3", tx_count); else pass_cnt++;
    total_cnt++; if ({rx_good, rx_bad} !== {32'd3, 32'd0}) $display("[TB] FAIL d5_rx_counts got %0d/%0d expected 3/0", rx_good, rx_bad); else pass_cnt++;
  endtask

  task automatic test_direct_seq;
    logic [31:0] seqs[$];
    int nvalid;
    do_reset(0);
    nvalid = 0;
    for (int i = 0; (i < 400) && (nvalid < 3); i++) begin
      @(negedge sys_clk);
      if ((xgmii_0_txc == 8'h00) && (xgmii_0_txd[15:0] == 16'h5341))
        seqs.push_back({xgmii_0_txd[23:16], xgmii_0_txd[31:24], xgmii_0_txd[39:32], xgmii_0_txd[47:40]});
      if (latency_valid) begin
        nvalid++;
        total_cnt++; if (latency !== 32'd0) $display("[TB] FAIL direct_latency got %0d expected 0", latency); else pass_cnt++;
      end
    end
    total_cnt++; if (nvalid !== 3) $display("[TB] FAIL direct_pulses got %0d expected 3", nvalid); else pass_cnt++;
    total_cnt++; if (seqs.size() < 3) $display("[TB] FAIL seq_seen got %0d expected 3", seqs.size()); else pass_cnt++;
    for (int i = 0; i < seqs.size() && i < 3; i++) begin
      total_cnt++; if (seqs[i] !== 32'(i)) $display("[TB] FAIL seq%0d got %0d expected %0d", i, seqs[i], i); else pass_cnt++;
    end
  endtask

  task automatic test_corrupt_and_flip;
    bit got;
    int pulses;
    do_reset(1);
    wait_valid(300, got);
    total_cnt++; if ({got, latency} !== {1'b1, 32'd5}) $display("[TB] FAIL pre_corrupt got %b/%0d expected 1/5", got, latency); else pass_cnt++;
    corrupt_hdr = 1'b1;
    pulses = 0;
    for (int i = 0; (i < 300) && (rx_bad == 32'd0); i++) begin
      @(negedge sys_clk);
      if (latency_valid) pulses++;
    end
    corrupt_hdr = 1'b0;
    total_cnt++; if (rx_bad !== 32'd1) $display("[TB] FAIL hdr_rx_bad got %0d expected 1", rx_bad); else pass_cnt++;
    total_cnt++; if (pulses !== 0) $display("[TB] FAIL hdr_no_valid got %0d expected 0", pulses); else pass_cnt++;
    total_cnt++; if ({latency, rx_good} !== {32'd5, 32'd1}) $display("[TB] FAIL hdr_keep got %0d/%0d expected 5/1", latency, rx_good); else pass_cnt++;
    flip_payload = 1'b1;
    pulses = 0;
    for (int i = 0; (i < 300) && (rx_bad == 32'd1) && (pulses == 0); i++) begin
      @(negedge sys_clk);
      if (latency_valid) pulses++;
    end
    flip_payload = 1'b0;
`ifdef MEASURE_FCS_EN
    total_cnt++; if ({rx_good, rx_bad} !== {32'd1, 32'd2}) $display("[TB] FAIL flip_counts got %0d/%0d expected 1/2", rx_good, rx_bad); else pass_cnt++;
`else
    total_cnt++; if ({rx_good, rx_bad} !== {32'd2, 32'd1}) $display("[TB] FAIL flip_counts got %0d/%0d expected 2/1", rx_good, rx_bad); else pass_cnt++;
`endif
    total_cnt++; if (latency !== 32'd5) $display("[TB] FAIL flip_latency got %0d expected 5", latency); else pass_cnt++;
  endtask

  task automatic test_manual_frames;
    logic [31:0] ts;
    do_reset(2);
    repeat (4) drive(IDLE_D, 8'hFF);
    ts = tb_cyc - 32'd1000;
    drive(START_D, 8'h01);
    for (int w = 0; w < 8; w++) drive(exp_word(w, 32'd7, ts), 8'h00);
    drive(TERM_D, 8'hFF);
    total_cnt++; if ({latency_valid, latency, rx_good} !== {1'b1, 32'd1000, 32'd1}) $display("[TB] FAIL man_good got %b/%0d/%0d expected 1/1000/1", latency_valid, latency, rx_good); else pass_cnt++;
    seen_valid = 1'b0;
    drive(IDLE_D, 8'hFF);
    drive(START_D, 8'h01);
    for (int w = 0; w < 7; w++) drive(exp_word(w, 32'd8, ts), 8'h00);
    drive(TERM_D, 8'hFF);
    drive(IDLE_D, 8'hFF);
    total_cnt++; if ({seen_valid, rx_bad, latency} !== {1'b0, 32'd1, 32'd1000}) $display("[TB] FAIL truncated got %b/%0d/%0d expected 0/1/1000", seen_valid, rx_bad, latency); else pass_cnt++;
    drive(START_D, 8'h01);
    for (int w = 0; w < 8; w++) drive(exp_word(w, 32'd9, ts), 8'h00);
    drive(64'h07070707FE0707FD, 8'hFF);
    drive(IDLE_D, 8'hFF);
    total_cnt++; if ({seen_valid, rx_bad} !== {1'b0, 32'd2}) $display("[TB] FAIL fe_lane got %b/%0d expected 0/2", seen_valid, rx_bad); else pass_cnt++;
    drive(64'hD55555FB07070707, 8'h1F);
    for (int w = 0; w < 8; w++) drive(exp_word(w, 32'd10, ts), 8'h00);
    drive(TERM_D, 8'hFF);
    drive(IDLE_D, 8'hFF);
    total_cnt++; if ({seen_valid, rx_good, rx_bad} !== {1'b0, 32'd1, 32'd2}) $display("[TB] FAIL lane4_start got %b/%0d/%0d expected 0/1/2", seen_valid, rx_good, rx_bad); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    bit got;
    bit found;
    do_reset(0);
    wait_valid(300, got);
    total_cnt++; if ({got, rx_good, tx_count} !== {1'b1, 32'd1, 32'd1}) $display("[TB] FAIL mid_pre got %b/%0d/%0d expected 1/1/1", got, rx_good, tx_count); else pass_cnt++;
    found = 1'b0;
    for (int i = 0; (i < 200) && !found; i++) begin
      @(negedge sys_clk);
      if (xgmii_0_txc == 8'h00) found = 1'b1;
    end
    #2 sys_rst = 1'b0;
    #1;
    total_cnt++; if ({found, xgmii_0_txd, xgmii_0_txc} !== {1'b1, IDLE_D, 8'hFF}) $display("[TB] FAIL mid_idle got %b/%h/%h expected 1/%h/ff", found, xgmii_0_txd, xgmii_0_txc, IDLE_D); else pass_cnt++;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (40) @(negedge sys_clk);
    total_cnt++; if ({tx_count, rx_good, rx_bad} !== 96'h0) $display("[TB] FAIL mid_counts got %0d/%0d/%0d expected 0/0/0", tx_count, rx_good, rx_bad); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_loop_delay5();
    test_direct_seq();
    test_corrupt_and_flip();
    test_manual_frames();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
